// File: rtl/nonogram_line_solver_if.sv
// Stream/board interface of the nonogram line-elimination engine.
// The option-FIFO side (master) drives words; the engine (slave) reports board state.
interface nonogram_line_solver_if #(
  parameter int SIZE  = 3,
  parameter int CNT_W = 7
);
  logic                              started;
  logic [SIZE-1:0]                   option;
  logic                              valid_op;
  logic                              ready;
  logic [2*SIZE-1:0][CNT_W-1:0]      old_options_amnt;
  logic [SIZE-1:0]                   out_option;
  logic                              put_back_to_FIFO;
  logic                              line_done;
  logic [CNT_W-1:0]                  new_options_amnt;
  logic [SIZE-1:0][SIZE-1:0]         known;
  logic [SIZE-1:0][SIZE-1:0]         assigned;
  logic                              solved;
  logic                              contradiction;

  modport master (
    output started, option, valid_op, old_options_amnt,
    input  ready, out_option, put_back_to_FIFO, line_done, new_options_amnt,
           known, assigned, solved, contradiction
  );

  modport slave (
    input  started, option, valid_op, old_options_amnt,
    output ready, out_option, put_back_to_FIFO, line_done, new_options_amnt,
           known, assigned, solved, contradiction
  );
endinterface

// File: rtl/nonogram_line_solver.sv
// Nonogram line-elimination engine: filters one line's options against the known board,
// echoes survivors for re-queue and fixes cells common to every survivor.
module nonogram_line_solver #(
  parameter int SIZE  = 3,
  parameter int CNT_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  nonogram_line_solver_if.slave bus
);
  localparam int NL    = 2 * SIZE;
  localparam int IDX_W = $clog2(NL);

  typedef enum logic [1:0] {IDLE, OPT, COMMIT} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               line_q, line_d;
  logic [CNT_W-1:0]               rem_q, rem_d;
  logic [CNT_W-1:0]               surv_q, surv_d;
  logic [SIZE-1:0]                and_q, and_d;
  logic [SIZE-1:0]                or_q, or_d;
  logic [NL-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [SIZE-1:0][SIZE-1:0]      known_q, known_d;
  logic [SIZE-1:0][SIZE-1:0]      assigned_q, assigned_d;
  logic                           solved_q, solved_d;
  logic                           contra_q, contra_d;
  logic                           put_back_q, put_back_d;
  logic [SIZE-1:0]                out_option_q, out_option_d;
  logic                           line_done_q, line_done_d;
  logic [CNT_W-1:0]               new_amnt_q, new_amnt_d;

  logic                           ready;
  logic                           accept;
  logic [IDX_W-1:0]               idx;
  logic                           idx_ok;
  logic [CNT_W-1:0]               cnt_sel;
  logic [SIZE-1:0]                line_known;
  logic [SIZE-1:0]                line_asg;
  logic                           consistent;

  assign ready  = (state_q != COMMIT);
  assign accept = bus.valid_op & ready;
  assign idx    = bus.option[IDX_W-1:0];
  assign idx_ok = {1'b0, idx} < (IDX_W+1)'(NL);

  // Line view of the board in option-bit order: position i sits at bit SIZE-1-i.
  always_comb begin
    line_known = '0;
    line_asg   = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (line_q == IDX_W'(r)) begin
          line_known[SIZE-1-c] = known_q[r][c];
          line_asg[SIZE-1-c]   = assigned_q[r][c];
        end
        if (line_q == IDX_W'(SIZE + c)) begin
          line_known[SIZE-1-r] = known_q[r][c];
          line_asg[SIZE-1-r]   = assigned_q[r][c];
        end
      end
    end
    consistent = (((bus.option ^ line_asg) & line_known) == '0);
  end

  // On started the fresh counts apply to the index taken in the same cycle.
  always_comb begin
    cnt_sel = '0;
    for (int l = 0; l < NL; l++)
      if (idx == IDX_W'(l))
        cnt_sel = bus.started ? bus.old_options_amnt[l] : cnt_q[l];
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    rem_d        = rem_q;
    surv_d       = surv_q;
    and_d        = and_q;
    or_d         = or_q;
    cnt_d        = cnt_q;
    known_d      = known_q;
    assigned_d   = assigned_q;
    solved_d     = &known_q;
    contra_d     = contra_q;
    put_back_d   = 1'b0;
    out_option_d = out_option_q;
    line_done_d  = 1'b0;
    new_amnt_d   = new_amnt_q;

    if (bus.started) begin
      cnt_d      = bus.old_options_amnt;
      known_d    = '0;
      assigned_d = '0;
      solved_d   = 1'b0;
      contra_d   = 1'b0;
      state_d    = IDLE;
      if (bus.valid_op && idx_ok) begin
        line_d  = idx;
        rem_d   = cnt_sel;
        and_d   = '1;
        or_d    = '0;
        surv_d  = '0;
        state_d = (cnt_sel == '0) ? COMMIT : OPT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && idx_ok) begin
            line_d  = idx;
            rem_d   = cnt_sel;
            and_d   = '1;
            or_d    = '0;
            surv_d  = '0;
            state_d = (cnt_sel == '0) ? COMMIT : OPT;
          end
        end
        OPT: begin
          if (accept) begin
            if (consistent) begin
              and_d        = and_q & bus.option;
              or_d         = or_q | bus.option;
              surv_d       = (surv_q == '1) ? surv_q : surv_q + 1'b1;
              put_back_d   = 1'b1;
              out_option_d = bus.option;
            end
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_d = COMMIT;
          end
        end
        COMMIT: begin
          // Only undecided cells are written; decided cells keep their value.
          for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
              if (surv_q != '0 && !known_q[r][c]) begin
                if (line_q == IDX_W'(r)) begin
                  if (and_q[SIZE-1-c]) begin
                    known_d[r][c] = 1'b1; assigned_d[r][c] = 1'b1;
                  end else if (!or_q[SIZE-1-c]) begin
                    known_d[r][c] = 1'b1; assigned_d[r][c] = 1'b0;
                  end
                end
                if (line_q == IDX_W'(SIZE + c)) begin
                  if (and_q[SIZE-1-r]) begin
                    known_d[r][c] = 1'b1; assigned_d[r][c] = 1'b1;
                  end else if (!or_q[SIZE-1-r]) begin
                    known_d[r][c] = 1'b1; assigned_d[r][c] = 1'b0;
                  end
                end
              end
            end
          end
          for (int l = 0; l < NL; l++)
            if (line_q == IDX_W'(l)) cnt_d[l] = surv_q;
          if (surv_q == '0) contra_d = 1'b1;
          line_done_d = 1'b1;
          new_amnt_d  = surv_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      rem_q        <= '0;
      surv_q       <= '0;
      and_q        <= '0;
      or_q         <= '0;
      cnt_q        <= '0;
      known_q      <= '0;
      assigned_q   <= '0;
      solved_q     <= 1'b0;
      contra_q     <= 1'b0;
      put_back_q   <= 1'b0;
      out_option_q <= '0;
      line_done_q  <= 1'b0;
      new_amnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      rem_q        <= rem_d;
      surv_q       <= surv_d;
      and_q        <= and_d;
      or_q         <= or_d;
      cnt_q        <= cnt_d;
      known_q      <= known_d;
      assigned_q   <= assigned_d;
      solved_q     <= solved_d;
      contra_q     <= contra_d;
      put_back_q   <= put_back_d;
      out_option_q <= out_option_d;
      line_done_q  <= line_done_d;
      new_amnt_q   <= new_amnt_d;
    end
  end

  assign bus.ready            = ready;
  assign bus.out_option       = out_option_q;
  assign bus.put_back_to_FIFO = put_back_q;
  assign bus.line_done        = line_done_q;
  assign bus.new_options_amnt = new_amnt_q;
  assign bus.known            = known_q;
  assign bus.assigned         = assigned_q;
  assign bus.solved           = solved_q;
  assign bus.contradiction    = contra_q;
endmodule

// File: tb/tb_nonogram_line_solver.sv
// Bench for nonogram_line_solver: directed table for the reference puzzle, hand-written
// reset/invalid-index sequences, and random puzzles against a cell-level board model.
module tb_nonogram_line_solver;
  localparam int S     = 3;
  localparam int CNT_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonogram_line_solver_if #(.SIZE(S), .CNT_W(CNT_W)) bus ();
  nonogram_line_solver #(.SIZE(S), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  logic [S-1:0]     pb_q[$];
  int               ld_cnt = 0;
  logic [CNT_W-1:0] ld_amnt = '0;
  int               cyc = 0;
  int               ld_cyc = 0;
  int               solved_cyc = -1;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.put_back_to_FIFO) pb_q.push_back(bus.out_option);
    if (bus.line_done) begin
      ld_cnt++;
      ld_amnt = bus.new_options_amnt;
      ld_cyc  = cyc;
    end
    if (bus.solved && solved_cyc < 0) solved_cyc = cyc;
  end

  // Board model: cells, per-line counts, sticky contradiction.
  bit mk[S][S];
  bit ma[S][S];
  int mcnt[2*S];
  bit mcontra;
  int tb_counts[2*S];

  function automatic void cell_of(input int L, input int i, output int r, output int c);
    if (L < S) begin r = L; c = i; end
    else       begin r = i; c = L - S; end
  endfunction

  task automatic model_reset();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin mk[r][c] = 0; ma[r][c] = 0; end
    for (int l = 0; l < 2*S; l++) mcnt[l] = tb_counts[l];
    mcontra = 0;
  endtask

  task automatic model_line(input int L, input logic [S-1:0] opts[$], output logic [S-1:0] surv[$]);
    int r, c;
    surv = {};
    foreach (opts[k]) begin
      bit ok;
      ok = 1;
      for (int i = 0; i < S; i++) begin
        cell_of(L, i, r, c);
        if (mk[r][c] && (ma[r][c] != opts[k][S-1-i])) ok = 0;
      end
      if (ok) surv.push_back(opts[k]);
    end
    if (surv.size() == 0) mcontra = 1;
    else begin
      for (int i = 0; i < S; i++) begin
        bit all1, all0;
        all1 = 1; all0 = 1;
        foreach (surv[k]) if (surv[k][S-1-i]) all0 = 0; else all1 = 0;
        cell_of(L, i, r, c);
        if (!mk[r][c]) begin
          if (all1)      begin mk[r][c] = 1; ma[r][c] = 1; end
          else if (all0) begin mk[r][c] = 1; ma[r][c] = 0; end
        end
      end
    end
    mcnt[L] = surv.size();
  endtask

  function automatic logic [S*S-1:0] flat(input bit b[S][S]);
    logic [S*S-1:0] v;
    v = '0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) v[r*S+c] = b[r][c];
    return v;
  endfunction

  function automatic bit model_solved();
    bit s;
    s = 1;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) if (!mk[r][c]) s = 0;
    return s;
  endfunction

  task automatic send(input logic [S-1:0] w);
    int n;
    n = 0;
    bus.option   = w;
    bus.valid_op = 1'b1;
    while (!bus.ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", 64'(bus.ready), 64'(1));
    @(negedge clk);
    bus.valid_op = 1'b0;
  endtask

  task automatic start_pulse(input int L);
    bus.started = 1'b1;
    for (int l = 0; l < 2*S; l++) bus.old_options_amnt[l] = CNT_W'(tb_counts[l]);
    bus.option   = S'(L);
    bus.valid_op = 1'b1;
    @(negedge clk);
    bus.started  = 1'b0;
    bus.valid_op = 1'b0;
  endtask

  // One line: index (optionally with started), its options, then compare everything.
  task automatic run_line(input int L, input logic [S-1:0] opts[$], input bit with_start, input string tag);
    logic [S-1:0] exp_pb[$];
    int ld0;
    pb_q.delete();
    ld0 = ld_cnt;
    if (with_start) model_reset();
    model_line(L, opts, exp_pb);
    if (with_start) start_pulse(L);
    else send(S'(L));
    foreach (opts[k]) send(opts[k]);
    repeat (3) @(negedge clk);
    check({tag, "_line_done"}, 64'(ld_cnt - ld0), 64'(1));
    check({tag, "_amnt"}, 64'(ld_amnt), 64'(exp_pb.size()));
    check({tag, "_pb_n"}, 64'(pb_q.size()), 64'(exp_pb.size()));
    if (pb_q.size() == exp_pb.size())
      foreach (exp_pb[k]) check({tag, "_pb_val"}, 64'(pb_q[k]), 64'(exp_pb[k]));
    check({tag, "_known"}, 64'(bus.known), 64'(flat(mk)));
    check({tag, "_assigned"}, 64'(bus.assigned & bus.known), 64'(flat(ma) & flat(mk)));
    check({tag, "_contra"}, 64'(bus.contradiction), 64'(mcontra));
    check({tag, "_solved"}, 64'(bus.solved), 64'(model_solved()));
  endtask

  typedef struct {
    bit           start;
    int           line;
    int           n;
    logic [S-1:0] o [4];
    int           exp_surv;
    bit           exp_solved;
    bit           exp_contra;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [S-1:0] q[$];
    logic [S-1:0] hb[S];
    int ld0;

    bus.started = 1'b0;
    bus.option = '0;
    bus.valid_op = 1'b0;
    bus.old_options_amnt = '0;

    tb_counts = '{2, 3, 1, 1, 2, 3};
    tbl[0] = '{1, 0, 2, '{3'b110, 3'b011, 3'b000, 3'b000}, 2, 0, 0};
    tbl[1] = '{0, 2, 1, '{3'b101, 3'b000, 3'b000, 3'b000}, 1, 0, 0};
    tbl[2] = '{0, 3, 1, '{3'b101, 3'b000, 3'b000, 3'b000}, 1, 0, 0};
    tbl[3] = '{0, 1, 3, '{3'b100, 3'b010, 3'b001, 3'b000}, 2, 0, 0};
    tbl[4] = '{0, 4, 2, '{3'b110, 3'b011, 3'b000, 3'b000}, 1, 0, 0};
    tbl[5] = '{0, 5, 3, '{3'b001, 3'b100, 3'b011, 3'b000}, 2, 0, 0};
    tbl[6] = '{0, 1, 2, '{3'b010, 3'b001, 3'b000, 3'b000}, 1, 1, 0};
    tbl[7] = '{0, 0, 2, '{3'b001, 3'b000, 3'b000, 3'b000}, 0, 1, 1};

    repeat (3) @(negedge clk);
    check("rst_known", 64'(bus.known), 64'(0));
    check("rst_assigned", 64'(bus.assigned), 64'(0));
    check("rst_flags", {61'(0), bus.solved, bus.contradiction, bus.line_done}, 64'(0));
    check("rst_ready", 64'(bus.ready), 64'(1));
    check("rst_pulse", {bus.put_back_to_FIFO, bus.out_option, bus.new_options_amnt}, 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reference puzzle 110/010/101.
    solved_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      q = {};
      for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].o[k]);
      run_line(tbl[i].line, q, tbl[i].start, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_surv", i), 64'(ld_amnt), 64'(tbl[i].exp_surv));
      check($sformatf("tbl%0d_solved", i), 64'(bus.solved), 64'(tbl[i].exp_solved));
      check($sformatf("tbl%0d_contra", i), 64'(bus.contradiction), 64'(tbl[i].exp_contra));
      if (i == 6) check("solved_latency", 64'(solved_cyc - ld_cyc), 64'(1));
    end
    check("final_board", 64'(bus.assigned), 64'(9'b101_010_011));

    // Out-of-range indices are ignored; the next valid line still works.
    pb_q.delete();
    ld0 = ld_cnt;
    send(3'd7);
    send(3'd6);
    repeat (3) @(negedge clk);
    check("badidx_no_done", 64'(ld_cnt - ld0), 64'(0));
    check("badidx_no_pb", 64'(pb_q.size()), 64'(0));
    check("badidx_ready", 64'(bus.ready), 64'(1));
    q = {3'b110};
    run_line(4, q, 0, "after_badidx");

    // Reset in the middle of a line discards it silently.
    start_pulse(5);
    send(3'b001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_known", 64'(bus.known), 64'(0));
    check("midrst_flags", {60'(0), bus.solved, bus.contradiction, bus.line_done, bus.put_back_to_FIFO}, 64'(0));
    check("midrst_ready", 64'(bus.ready), 64'(1));
    check("midrst_amnt", 64'(bus.new_options_amnt), 64'(0));
    pb_q.delete();
    ld0 = ld_cnt;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 64'(ld_cnt - ld0), 64'(0));
    check("midrst_no_pb", 64'(pb_q.size()), 64'(0));
    q = {3'b110, 3'b011};
    run_line(0, q, 1, "restart");

    // Random puzzles against the model.
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < S; r++) hb[r] = S'($urandom);
      for (int l = 0; l < 2*S; l++) tb_counts[l] = $urandom_range(0, 4);
      for (int t = 0; t < 12; t++) begin
        int L, n;
        L = $urandom_range(0, 2*S-1);
        n = (t == 0) ? tb_counts[L] : mcnt[L];
        q = {};
        for (int k = 0; k < n; k++) begin
          logic [S-1:0] o;
          if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < S; i++) begin
              int r, c;
              cell_of(L, i, r, c);
              o[S-1-i] = hb[r][S-1-c];
            end
          end else o = S'($urandom);
          q.push_back(o);
        end
        run_line(L, q, t == 0, $sformatf("rnd%0d_%0d", p, t));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
